// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the slow-clock period meter.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STALL = 2'd3
  } meter_state_t;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned METER_TIMEOUT     = 4_000_000;
  localparam int unsigned METER_CNT_W       = 25;
  localparam int unsigned METER_SYNC_STAGES = 2;

endpackage

// File: rtl/sig_edge_sync.sv
// Multi-flop synchronizer with delayed copy for rise/fall detection of a slow async pin.
module sig_edge_sync
  import clock_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = METER_SYNC_STAGES
) (
  input  logic C_50Mhz,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Both edges see the same pipeline depth, so measured widths stay exact.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high time, low time and period of a slow square wave in C_50Mhz cycles.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = METER_CNT_W,
  parameter int unsigned TIMEOUT     = METER_TIMEOUT,
  parameter int unsigned SYNC_STAGES = METER_SYNC_STAGES
) (
  input  logic             C_50Mhz,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic [CNT_W:0]   period_cycles,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic sig_level, sig_rise, sig_fall;
  logic rise_ev, fall_ev;

  sig_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .C_50Mhz (C_50Mhz),
    .rst     (rst),
    .async_in(sig_in),
    .level   (sig_level),
    .rise    (sig_rise),
    .fall    (sig_fall)
  );

  assign rise_ev = sig_rise & sig_level;
  assign fall_ev = sig_fall & ~sig_level;

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_sat;

  // Saturating increment; the counter never wraps past TIMEOUT.
  assign cnt_sat = (cnt_q == TIMEOUT_C);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + ONE_C;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_len_d = high_len_q;
    high_d     = high_q;
    low_d      = low_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;

    if (clear) begin
      state_d   = IDLE;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_ev) begin
            cnt_d   = ONE_C;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall_ev) begin
            high_len_d = cnt_q;
            cnt_d      = ONE_C;
            state_d    = LOW;
          end else if (cnt_sat) begin
            state_d   = STALL;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise_ev) begin
            high_d   = high_len_q;
            low_d    = cnt_q;
            period_d = {1'b0, high_len_q} + {1'b0, cnt_q};
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = ONE_C;
            state_d  = HIGH;
          end else if (cnt_sat) begin
            state_d   = STALL;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STALL: begin
          // Partial period is discarded; the next rise only restarts the high phase.
          if (rise_ev) begin
            timeout_d = 1'b0;
            cnt_d     = ONE_C;
            state_d   = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_len_q <= '0;
      high_q     <= '0;
      low_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_len_q <= high_len_d;
      high_q     <= high_d;
      low_q      <= low_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
    end
  end

  assign high_cycles   = high_q;
  assign low_cycles    = low_q;
  assign period_cycles = period_q;
  assign meas_valid    = valid_q;
  assign locked        = locked_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: directed waveforms, queued expectations, decoupled monitor.
module tb_clock_period_meter;

  localparam int unsigned CNT_W   = 25;
  localparam int unsigned TMO     = 1000;
  localparam int unsigned SYNC_ST = 2;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             clear;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0]   period_cycles;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  typedef struct {
    int unsigned h;
    int unsigned l;
    int unsigned p;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_valid = 1'b0;

  clock_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(SYNC_ST)
  ) dut (
    .C_50Mhz      (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .clear        (clear),
    .high_cycles  (high_cycles),
    .low_cycles   (low_cycles),
    .period_cycles(period_cycles),
    .meas_valid   (meas_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic drive(input logic lv, input int n);
    sig_in = lv;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned h, input int unsigned l);
    exp_t e;
    e.h = h;
    e.l = l;
    e.p = h + l;
    exp_q.push_back(e);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: every meas_valid must be a single cycle and match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (meas_valid) begin
        n_tests++;
        if (prev_valid) begin
          n_fail++;
          $display("FAIL valid_width: meas_valid high on consecutive cycles at %0t", $time);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: high=%0d low=%0d period=%0d at %0t",
                   high_cycles, low_cycles, period_cycles, $time);
        end else begin
          e = exp_q.pop_front();
          if (32'(high_cycles) !== e.h || 32'(low_cycles) !== e.l || 32'(period_cycles) !== e.p) begin
            n_fail++;
            $display("FAIL meas_value: got h=%0d l=%0d p=%0d expected h=%0d l=%0d p=%0d",
                     high_cycles, low_cycles, period_cycles, e.h, e.l, e.p);
          end
        end
      end
      prev_valid = meas_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_high",    32'(high_cycles),   0);
    check("rst_low",     32'(low_cycles),    0);
    check("rst_period",  32'(period_cycles), 0);
    check("rst_valid",   32'(meas_valid),    0);
    check("rst_locked",  32'(locked),        0);
    check("rst_timeout", 32'(timeout),       0);
    rst = 1'b0;
    drive(1'b0, 10);

    // Symmetric square wave: first rise only starts the high phase.
    for (int i = 0; i < 3; i++) begin
      if (i == 1) check("locked_before_2nd_rise", 32'(locked), 0);
      if (i > 0) push(500, 500);
      drive(1'b1, 500);
      drive(1'b0, 500);
    end
    push(500, 500);
    drive(1'b1, 20);
    check("sq_queue_empty", 32'(exp_q.size()), 0);
    check("sq_locked", 32'(locked), 1);

    pulse_clear();
    check("clr_locked",  32'(locked),      0);
    check("clr_timeout", 32'(timeout),     0);
    check("clr_hold",    32'(high_cycles), 500);
    drive(1'b0, 10);

    // Asymmetric 37/63 wave.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push(37, 63);
      drive(1'b1, 37);
      drive(1'b0, 63);
    end
    push(37, 63);
    drive(1'b1, 20);
    check("asym_queue_empty", 32'(exp_q.size()), 0);

    // Held low: fall detect after SYNC+1 cycles, then TIMEOUT cycles to STALL.
    sig_in = 1'b0;
    repeat (SYNC_ST + TMO) @(negedge clk);
    check("tmo_not_yet",        32'(timeout), 0);
    check("tmo_locked_not_yet", 32'(locked),  1);
    @(negedge clk);
    check("tmo_set",         32'(timeout),       1);
    check("tmo_locked_drop", 32'(locked),        0);
    check("tmo_hold_high",   32'(high_cycles),   37);
    check("tmo_hold_low",    32'(low_cycles),    63);
    check("tmo_hold_period", 32'(period_cycles), 100);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    check("tmo_before_rise_detect", 32'(timeout), 1);
    @(negedge clk);
    check("tmo_cleared_by_rise", 32'(timeout), 0);
    repeat (37) @(negedge clk);
    drive(1'b0, 60);
    push(40, 60);
    drive(1'b1, 10);
    check("tmo_recover_queue_empty", 32'(exp_q.size()), 0);

    // clear coincident with rise detect drops the edge.
    drive(1'b0, 50);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    check("clr_edge_locked", 32'(locked),      0);
    check("clr_edge_hold",   32'(high_cycles), 40);
    drive(1'b1, 20);
    drive(1'b0, 30);
    drive(1'b1, 25);
    drive(1'b0, 35);
    check("clr_edge_no_early_valid", 32'(locked), 0);
    push(25, 35);
    drive(1'b1, 10);
    check("clr_edge_queue_empty", 32'(exp_q.size()), 0);
    check("clr_edge_relocked",    32'(locked),       1);

    // Asynchronous reset mid-LOW, between clock edges.
    drive(1'b0, 20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_high",    32'(high_cycles),   0);
    check("arst_low",     32'(low_cycles),    0);
    check("arst_period",  32'(period_cycles), 0);
    check("arst_locked",  32'(locked),        0);
    check("arst_timeout", 32'(timeout),       0);
    check("arst_valid",   32'(meas_valid),    0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5);
    drive(1'b1, 30);
    drive(1'b0, 30);
    check("arst_one_rise_locked", 32'(locked),      0);
    check("arst_one_rise_high",   32'(high_cycles), 0);
    push(30, 30);
    drive(1'b1, 10);
    check("arst_queue_empty", 32'(exp_q.size()), 0);

    // One-cycle glitch inside a 50/50 wave.
    pulse_clear();
    drive(1'b0, 10);
    drive(1'b1, 50);
    drive(1'b0, 50);
    push(50, 50);
    drive(1'b1, 50);
    drive(1'b0, 20);
    push(50, 20);
    drive(1'b1, 1);
    drive(1'b0, 29);
    push(1, 29);
    drive(1'b1, 50);
    drive(1'b0, 50);
    push(50, 50);
    drive(1'b1, 10);
    check("glitch_queue_empty", 32'(exp_q.size()), 0);

    // Stuck high: counter saturates and the block stalls without publishing.
    drive(1'b1, 1010);
    check("sat_timeout",   32'(timeout),     1);
    check("sat_locked",    32'(locked),      0);
    check("sat_hold_high", 32'(high_cycles), 50);
    drive(1'b0, 20);
    check("stall_fall_ignored", 32'(timeout), 1);

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
